dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_byte_ram.sv | 33 +++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_pkg: shared widths, R/W encodings and FSM state encodings   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dmem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WAIT  = 3'd1;
  localparam state_t ST_BYTE0 = 3'd2;
  localparam state_t ST_BYTE1 = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/dmem_byte_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_byte_ram: single-port byte RAM, synchronous write and read  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          CLOCK_50,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH_BYTES];
  logic [7:0] rdata_q;

  // Read returns the old contents when the same address is written.
  always_ff @(posedge CLOCK_50) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_responder: 16-bit load/store responder over a byte RAM      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_RW,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              BUSY
);

  localparam int         RAM_AW    = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          lo_q, lo_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                w_accept;
  logic                w_req_err;
  logic                ram_we;
  logic [RAM_AW-1:0]   ram_addr;
  logic [7:0]          ram_wdata;
  logic [7:0]          ram_rdata;

  assign REQ_READY = (state_q == ST_IDLE) && !reset;
  assign w_accept  = REQ_VALID && REQ_READY;
  assign w_req_err = 32'(REQ_ADDR) > 32'(DEPTH_BYTES - 2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          addr_d  = REQ_ADDR[RAM_AW-1:0];
          rw_d    = REQ_RW;
          wdata_d = REQ_WDATA;
          cnt_d   = WAIT_LOAD;
          if (w_req_err) begin
            state_d = ST_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_BYTE0;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_BYTE0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_BYTE0: begin
        if (rw_q == RW_READ) begin
          lo_d = ram_rdata;
        end
        state_d = ST_BYTE1;
      end
      ST_BYTE1: begin
        state_d = ST_RESP;
        err_d   = 1'b0;
        rdata_d = (rw_q == RW_READ) ? {ram_rdata, lo_q} : '0;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Reads present the address one state early so the registered RAM output
  // lines up with BYTE0/BYTE1; writes use the address of the current byte.
  always_comb begin
    ram_addr = addr_q;
    case (state_q)
      ST_IDLE:  ram_addr = REQ_ADDR[RAM_AW-1:0];
      ST_BYTE0: if (rw_q == RW_READ) ram_addr = addr_q + RAM_AW'(1);
      ST_BYTE1: ram_addr = addr_q + RAM_AW'(1);
      default:  ram_addr = addr_q;
    endcase
  end

  assign ram_we    = !reset && (rw_q == RW_WRITE) &&
                     ((state_q == ST_BYTE0) || (state_q == ST_BYTE1));
  assign ram_wdata = (state_q == ST_BYTE1) ? wdata_q[15:8] : wdata_q[7:0];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rw_q    <= RW_READ;
      wdata_q <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  dmem_byte_ram #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (RAM_AW)
  ) u_ram (
    .CLOCK_50 (CLOCK_50),
    .we_i     (ram_we),
    .addr_i   (ram_addr),
    .wdata_i  (ram_wdata),
    .rdata_o  (ram_rdata)
  );

  assign RSP_VALID = (state_q == ST_RESP);
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_responder: scoreboard bench for dmem_responder           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int W     = 1;
  localparam int DEPTH = 4096;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_RW    = 1'b0;
  logic [15:0] REQ_ADDR  = '0;
  logic [15:0] REQ_WDATA = '0;
  logic        RSP_VALID;
  logic [15:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        BUSY;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_RW    (REQ_RW),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .BUSY      (BUSY)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc  = 0;
  int   npass = 0;
  int   ntot  = 0;
  int   nrsp  = 0;
  logic prev_v = 1'b0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every response pops one expectation.
  always @(negedge CLOCK_50) begin
    if (RSP_VALID) begin
      nrsp++;
      chk("rsp_pulse_width", 32'(prev_v), 32'd0);
      if (sb.size() == 0) begin
        ntot++;
        $display("FAIL rsp_unexpected: got response rdata %0h err %0b, expected none", RSP_RDATA, RSP_ERR);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", 32'(RSP_RDATA), 32'(e.rdata));
        chk("rsp_err", 32'(RSP_ERR), 32'(e.err));
        chk("rsp_latency", cyc, e.due);
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      chk("rsp_missing", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    prev_v = RSP_VALID;
  end

  // Called and returns on a negedge; acc is the cycle number of the accept.
  task automatic issue(input logic rw, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input logic exp_err,
                       input bit push, input bit keep, output int acc);
    exp_t x;
    REQ_RW = rw; REQ_ADDR = addr; REQ_WDATA = wd; REQ_VALID = 1'b1;
    for (int k = 0; k < 60 && !REQ_READY; k++) @(negedge CLOCK_50);
    if (!REQ_READY) begin
      ntot++;
      $display("FAIL req_accept_timeout: REQ_READY got 0 expected 1 for addr %0h", addr);
      REQ_VALID = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (push) begin
      x.rdata = exp_rd; x.err = exp_err; x.due = cyc + (exp_err ? 1 : 3 + W);
      sb.push_back(x);
    end
    @(negedge CLOCK_50);
    if (!keep) begin
      REQ_VALID = 1'b0;
      REQ_RW = ~rw; REQ_ADDR = 16'hFFFF; REQ_WDATA = ~wd;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb.size() > 0; k++) @(negedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  initial begin
    int a, b, n0;
    logic [7:0] old_ff;

    // Reset state
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_ready", 32'(REQ_READY), 0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 0);
    chk("rst_rdata", 32'(RSP_RDATA), 0);
    chk("rst_busy", 32'(BUSY), 0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("rst_ready_after", 32'(REQ_READY), 1);

    // Aligned write then read
    issue(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1, 0, a);
    issue(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1, 0, a);
    drain();
    chk("bd_0010", 32'(dut.u_ram.mem[16'h10]), 32'hEF);
    chk("bd_0011", 32'(dut.u_ram.mem[16'h11]), 32'hBE);

    // Unaligned accesses
    issue(1'b1, 16'h001F, 16'hAA00, 16'h0000, 1'b0, 1, 0, a);
    issue(1'b1, 16'h0021, 16'h1234, 16'h0000, 1'b0, 1, 0, a);
    issue(1'b0, 16'h0020, 16'h0000, 16'h34AA, 1'b0, 1, 0, a);
    issue(1'b0, 16'h0021, 16'h0000, 16'h1234, 1'b0, 1, 0, a);
    drain();
    chk("bd_0022", 32'(dut.u_ram.mem[16'h22]), 32'h12);

    // Range errors, including the last in-range address pair
    old_ff = dut.u_ram.mem[16'hFFF];
    issue(1'b0, 16'h0FFF, 16'h0000, 16'h0000, 1'b1, 1, 0, a);
    issue(1'b1, 16'h2000, 16'h5555, 16'h0000, 1'b1, 1, 0, a);
    issue(1'b1, 16'h0FFE, 16'h9876, 16'h0000, 1'b0, 1, 0, a);
    issue(1'b0, 16'h0FFE, 16'h0000, 16'h9876, 1'b0, 1, 0, a);
    drain();
    chk("bd_0fff_after_err", 32'(dut.u_ram.mem[16'hFFF]), 32'h98);
    chk("bd_0fff_before", 32'(old_ff), 32'(old_ff ^ 8'h00));
    issue(1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1, 0, a);
    drain();
    chk("bd_0fff_err_nowrite", 32'(dut.u_ram.mem[16'hFFF]), 32'h98);

    // Back-to-back with REQ_VALID held high
    issue(1'b1, 16'h0050, 16'h0000, 16'h0000, 1'b0, 1, 0, a);
    issue(1'b1, 16'h0050, 16'h1111, 16'h0000, 1'b0, 1, 1, a);
    issue(1'b0, 16'h0050, 16'hFFFF, 16'h1111, 1'b0, 1, 0, b);
    chk("accept_spacing", b - a, 4 + W);
    drain();

    // Reset during BYTE1 of a write
    issue(1'b1, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1, 0, a);
    drain();
    n0 = nrsp;
    issue(1'b1, 16'h0040, 16'hCAFE, 16'h0000, 1'b0, 0, 0, a);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("abort_busy", 32'(BUSY), 1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("abort_ready", 32'(REQ_READY), 1);
    for (int k = 0; k < 8; k++) @(negedge CLOCK_50);
    chk("abort_no_rsp", nrsp, n0);
    chk("abort_bd_0040", 32'(dut.u_ram.mem[16'h40]), 32'hFE);
    chk("abort_bd_0041", 32'(dut.u_ram.mem[16'h41]), 32'h00);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
